// File: rtl/alu_result_buffer_if.sv
// Handshake and data bundle between the ALU, alu_result_buffer and the bus/control side.
// The slave modport is the buffer; the master modport is the producer/consumer environment.
interface alu_result_buffer_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
);
  logic [WIDTH-1:0]         in_lo;
  logic [WIDTH-1:0]         in_hi;
  logic                     in_carry;
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         out_lo;
  logic [WIDTH-1:0]         out_hi;
  logic                     out_zero;
  logic                     out_neg;
  logic                     out_carry;
  logic                     out_valid;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   count;

  modport slave (
    input  in_lo, in_hi, in_carry, in_valid, out_ready,
    output in_ready, out_lo, out_hi, out_zero, out_neg, out_carry, out_valid, count
  );

  modport master (
    output in_lo, in_hi, in_carry, in_valid, out_ready,
    input  in_ready, out_lo, out_hi, out_zero, out_neg, out_carry, out_valid, count
  );
endinterface

// File: rtl/alu_result_buffer.sv
// In-order ALU result queue (ZHI/ZLO + zero/neg/carry flags) replacing the single Z register.
// Define ALU_RESULT_BYPASS_EN to let a word pass straight through when the queue is empty.
module alu_result_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                clock,
  input  logic                clear,
  alu_result_buffer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             carry;
    logic             zero;
    logic             neg;
  } entry_t;

  // Handshake: a push happens on in_valid && in_ready, a pop on out_valid && out_ready;
  // in_ready depends only on the registered count, never on out_ready.
  entry_t          mem [DEPTH];
  entry_t          last_q;
  entry_t          in_entry;
  entry_t          head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic            bypass_take;
  logic            out_valid_c;

  always_comb begin
    in_entry       = '0;
    in_entry.hi    = bus.in_hi;
    in_entry.lo    = bus.in_lo;
    in_entry.carry = bus.in_carry;
    in_entry.zero  = (bus.in_lo == '0);
    in_entry.neg   = bus.in_lo[WIDTH-1];
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // last_q keeps the most recently consumed word so an empty buffer holds its outputs.
  always_comb begin
    head        = last_q;
    out_valid_c = 1'b0;
    bypass_take = 1'b0;
`ifdef ALU_RESULT_BYPASS_EN
    out_valid_c = !empty || bus.in_valid;
    bypass_take = empty && bus.in_valid && bus.out_ready;
    if (!empty) begin
      head = mem[rd_ptr];
    end else if (bus.in_valid) begin
      head = in_entry;
    end
`else
    out_valid_c = !empty;
    if (!empty) begin
      head = mem[rd_ptr];
    end
`endif
  end

  assign push = bus.in_valid && !full && !bypass_take;
  assign pop  = !empty && bus.out_ready;

  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      last_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr];
      end else if (bypass_take) begin
        last_q <= in_entry;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Storage itself needs no reset: clearing the pointers and count discards every entry.
  always_ff @(posedge clock) begin
    if (push && !clear) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  assign bus.in_ready  = !full;
  assign bus.out_valid = out_valid_c;
  assign bus.out_lo    = head.lo;
  assign bus.out_hi    = head.hi;
  assign bus.out_zero  = head.zero;
  assign bus.out_neg   = head.neg;
  assign bus.out_carry = head.carry;
  assign bus.count     = count_q;
endmodule
